// File: rtl/operand_dispatch_rs_pkg.sv
// operand_dispatch_rs_pkg: shared tags, idle value, opcodes and entry state encoding
package operand_dispatch_rs_pkg;
    localparam int NO_TAG = 0;
    localparam logic [15:0] SEM_VALOR_DEF = 16'hFFF0;
    localparam logic [2:0] OP_LOAD = 3'd5;
    localparam logic [2:0] OP_STORE = 3'd6;
    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } slot_state_t;
endpackage

// File: rtl/operand_dispatch_rs_if.sv
// operand_dispatch_rs_if: allocation, CDB and functional-unit handshake bundle
interface operand_dispatch_rs_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W = 3,
    parameter int NENT = 4,
    parameter int A_W = 7
);
    logic Flush, Alloc_valid, Alloc_ready, Alloc_use_A, CDB_valid, Uf_valid, Uf_ready;
    logic [2:0] Alloc_op, Uf_op;
    logic [DATA_W-1:0] Alloc_Vj, Alloc_Vk, CDB_data, Uf_op0, Uf_op1, Uf_op2;
    logic [TAG_W-1:0] Alloc_Qj, Alloc_Qk, Alloc_dst, CDB_tag, Uf_dst;
    logic [A_W-1:0] Alloc_A;
    logic [NENT-1:0] Busy_mask;
    modport master (
        output Flush, Alloc_valid, Alloc_op, Alloc_Vj, Alloc_Vk, Alloc_Qj, Alloc_Qk, Alloc_A,
               Alloc_use_A, Alloc_dst, CDB_valid, CDB_tag, CDB_data, Uf_ready,
        input  Alloc_ready, Uf_valid, Uf_op, Uf_dst, Uf_op0, Uf_op1, Uf_op2, Busy_mask
    );
    modport slave (
        input  Flush, Alloc_valid, Alloc_op, Alloc_Vj, Alloc_Vk, Alloc_Qj, Alloc_Qk, Alloc_A,
               Alloc_use_A, Alloc_dst, CDB_valid, CDB_tag, CDB_data, Uf_ready,
        output Alloc_ready, Uf_valid, Uf_op, Uf_dst, Uf_op0, Uf_op1, Uf_op2, Busy_mask
    );
endinterface

// File: rtl/operand_dispatch_rs_slot.sv
// operand_dispatch_rs_slot: one pending op with CDB snoop and same-cycle alloc bypass
module operand_dispatch_rs_slot
    import operand_dispatch_rs_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TAG_W = 3,
    parameter int A_W = 7
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              flush,
    input  logic              alloc_en,
    input  logic [2:0]        alloc_op,
    input  logic [DATA_W-1:0] alloc_vj,
    input  logic [DATA_W-1:0] alloc_vk,
    input  logic [TAG_W-1:0]  alloc_qj,
    input  logic [TAG_W-1:0]  alloc_qk,
    input  logic [A_W-1:0]    alloc_a,
    input  logic              alloc_use_a,
    input  logic [TAG_W-1:0]  alloc_dst,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              take,
    output logic              busy,
    output logic              ready,
    output logic [2:0]        op,
    output logic [TAG_W-1:0]  dst,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk,
    output logic [DATA_W-1:0] op2
);
    slot_state_t state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [TAG_W-1:0] dst_q, dst_d, qj_q, qj_d, qk_q, qk_d;
    logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
    logic [A_W-1:0] a_q, a_d;
    logic use_a_q, use_a_d, cdb_hit;

    // Entry lifecycle: load on alloc (with bypass), capture broadcasts while waiting, free on dispatch
    always_comb begin
        cdb_hit = cdb_valid && cdb_tag != TAG_W'(NO_TAG);
        state_d = state_q;
        op_d = op_q;
        dst_d = dst_q;
        vj_d = vj_q;
        vk_d = vk_q;
        qj_d = qj_q;
        qk_d = qk_q;
        a_d = a_q;
        use_a_d = use_a_q;
        if (flush) begin
            state_d = ST_FREE;
        end else if (state_q == ST_FREE && alloc_en) begin
            op_d = alloc_op;
            dst_d = alloc_dst;
            a_d = alloc_a;
            use_a_d = alloc_use_a;
            vj_d = (cdb_hit && cdb_tag == alloc_qj) ? cdb_data : alloc_vj;
            qj_d = (cdb_hit && cdb_tag == alloc_qj) ? '0 : alloc_qj;
            vk_d = (cdb_hit && cdb_tag == alloc_qk) ? cdb_data : alloc_vk;
            qk_d = (cdb_hit && cdb_tag == alloc_qk) ? '0 : alloc_qk;
            state_d = (qj_d == '0 && qk_d == '0) ? ST_READY : ST_WAIT;
        end else if (state_q == ST_WAIT) begin
            vj_d = (cdb_hit && cdb_tag == qj_q) ? cdb_data : vj_q;
            qj_d = (cdb_hit && cdb_tag == qj_q) ? '0 : qj_q;
            vk_d = (cdb_hit && cdb_tag == qk_q) ? cdb_data : vk_q;
            qk_d = (cdb_hit && cdb_tag == qk_q) ? '0 : qk_q;
            state_d = (qj_d == '0 && qk_d == '0) ? ST_READY : ST_WAIT;
        end else if (state_q == ST_READY && take) begin
            state_d = ST_FREE;
        end
    end

    // Entry registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_FREE;
            op_q <= '0;
            dst_q <= '0;
            vj_q <= '0;
            vk_q <= '0;
            qj_q <= '0;
            qk_q <= '0;
            a_q <= '0;
            use_a_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            dst_q <= dst_d;
            vj_q <= vj_d;
            vk_q <= vk_d;
            qj_q <= qj_d;
            qk_q <= qk_d;
            a_q <= a_d;
            use_a_q <= use_a_d;
        end
    end

    assign busy = state_q != ST_FREE;
    assign ready = state_q == ST_READY;
    assign op = op_q;
    assign dst = dst_q;
    assign vj = vj_q;
    assign vk = vk_q;
    assign op2 = use_a_q ? {{(DATA_W-A_W){1'b0}}, a_q} : vk_q;
endmodule

// File: rtl/operand_dispatch_rs.sv
// operand_dispatch_rs: operand collector with lowest-free alloc and round-robin registered dispatch
module operand_dispatch_rs
    import operand_dispatch_rs_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TAG_W = 3,
    parameter int NENT = 4,
    parameter int A_W = 7,
    parameter logic [DATA_W-1:0] SEM_VALOR = SEM_VALOR_DEF
) (
    input logic Clock,
    input logic Reset,
    operand_dispatch_rs_if.slave bus
);
    localparam int PW = (NENT > 1) ? $clog2(NENT) : 1;

    logic [NENT-1:0] busy, rdy, alloc_en, take;
    logic [2:0] s_op [NENT];
    logic [TAG_W-1:0] s_dst [NENT];
    logic [DATA_W-1:0] s_vj [NENT], s_vk [NENT], s_op2 [NENT];
    logic found, load;
    logic [PW-1:0] pick, cand, rr_q, rr_d;
    int sum;
    logic valid_q, valid_d;
    logic [DATA_W-1:0] op0_q, op0_d, op1_q, op1_d, op2_q, op2_d;
    logic [2:0] uop_q, uop_d;
    logic [TAG_W-1:0] udst_q, udst_d;

    // Lowest-index free entry; busy+1 isolates the first zero bit of busy
    assign alloc_en = (bus.Alloc_valid && !(&busy)) ? (~busy & (busy + NENT'(1))) : '0;
    assign load = !valid_q || bus.Uf_ready;
    assign take = (load && found) ? (NENT'(1) << pick) : '0;

    for (genvar i = 0; i < NENT; i++) begin : g_slot
        operand_dispatch_rs_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W), .A_W(A_W)) u_slot (
            .Clock(Clock), .Reset(Reset), .flush(bus.Flush), .alloc_en(alloc_en[i]),
            .alloc_op(bus.Alloc_op), .alloc_vj(bus.Alloc_Vj), .alloc_vk(bus.Alloc_Vk),
            .alloc_qj(bus.Alloc_Qj), .alloc_qk(bus.Alloc_Qk), .alloc_a(bus.Alloc_A),
            .alloc_use_a(bus.Alloc_use_A), .alloc_dst(bus.Alloc_dst),
            .cdb_valid(bus.CDB_valid), .cdb_tag(bus.CDB_tag), .cdb_data(bus.CDB_data),
            .take(take[i]), .busy(busy[i]), .ready(rdy[i]), .op(s_op[i]), .dst(s_dst[i]),
            .vj(s_vj[i]), .vk(s_vk[i]), .op2(s_op2[i])
        );
    end

    // Round-robin pick: first READY entry scanning upward from rr_ptr with wrap
    always_comb begin
        found = 1'b0;
        pick = '0;
        sum = 0;
        cand = '0;
        for (int k = 0; k < NENT; k++) begin
            sum = int'(rr_q) + k;
            cand = PW'(sum >= NENT ? sum - NENT : sum);
            if (!found && rdy[cand]) begin
                found = 1'b1;
                pick = cand;
            end
        end
    end

    // Output stage: hold while stalled, load the pick or go idle otherwise; flush keeps rr_ptr
    always_comb begin
        valid_d = valid_q;
        op0_d = op0_q;
        op1_d = op1_q;
        op2_d = op2_q;
        uop_d = uop_q;
        udst_d = udst_q;
        rr_d = rr_q;
        if (bus.Flush) begin
            valid_d = 1'b0;
            op0_d = SEM_VALOR;
            op1_d = SEM_VALOR;
            op2_d = SEM_VALOR;
            uop_d = '0;
            udst_d = '0;
        end else if (load && found) begin
            valid_d = 1'b1;
            op0_d = s_vk[pick];
            op1_d = s_vj[pick];
            op2_d = s_op2[pick];
            uop_d = s_op[pick];
            udst_d = s_dst[pick];
            rr_d = (pick == PW'(NENT - 1)) ? '0 : pick + PW'(1);
        end else if (load) begin
            valid_d = 1'b0;
            op0_d = SEM_VALOR;
            op1_d = SEM_VALOR;
            op2_d = SEM_VALOR;
        end
    end

    // Output and arbiter registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            valid_q <= 1'b0;
            op0_q <= SEM_VALOR;
            op1_q <= SEM_VALOR;
            op2_q <= SEM_VALOR;
            uop_q <= '0;
            udst_q <= '0;
            rr_q <= '0;
        end else begin
            valid_q <= valid_d;
            op0_q <= op0_d;
            op1_q <= op1_d;
            op2_q <= op2_d;
            uop_q <= uop_d;
            udst_q <= udst_d;
            rr_q <= rr_d;
        end
    end

    assign bus.Alloc_ready = !(&busy);
    assign bus.Busy_mask = busy;
    assign bus.Uf_valid = valid_q;
    assign bus.Uf_op0 = op0_q;
    assign bus.Uf_op1 = op1_q;
    assign bus.Uf_op2 = op2_q;
    assign bus.Uf_op = uop_q;
    assign bus.Uf_dst = udst_q;
endmodule

// File: tb/tb_operand_dispatch_rs.sv
// tb_operand_dispatch_rs: vector table, directed corner sequences and random run against a reference model
module tb_operand_dispatch_rs;
    localparam int N = 4;
    localparam logic [15:0] SEM = 16'hFFF0;

    logic Clock = 1'b0;
    logic Reset;
    int checks = 0;
    int failures = 0;

    operand_dispatch_rs_if #(.DATA_W(16), .TAG_W(3), .NENT(N), .A_W(7)) bus ();
    operand_dispatch_rs #(.DATA_W(16), .TAG_W(3), .NENT(N), .A_W(7)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic av; logic [2:0] op; logic [15:0] vj, vk; logic [2:0] qj, qk; logic [6:0] a;
        logic ua; logic [2:0] dst; logic cv; logic [2:0] ct; logic [15:0] cd; logic ur;
        logic [3:0] e_busy; logic e_valid; logic [15:0] e0, e1, e2; logic [2:0] e_dst;
    } vec_t;
    vec_t tv [12];

    // reference model: a pool of pending ops plus the output register
    logic m_busy [N];
    logic [2:0] m_op [N], m_dst [N], m_qj [N], m_qk [N];
    logic [15:0] m_vj [N], m_vk [N];
    logic [6:0] m_a [N];
    logic m_ua [N];
    logic m_valid;
    logic [15:0] m_o0, m_o1, m_o2;
    logic [2:0] m_uop, m_udst;
    int m_rr;
    logic [15:0] acc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        bus.Flush = 0; bus.Alloc_valid = 0; bus.Alloc_op = 0; bus.Alloc_Vj = 0; bus.Alloc_Vk = 0;
        bus.Alloc_Qj = 0; bus.Alloc_Qk = 0; bus.Alloc_A = 0; bus.Alloc_use_A = 0; bus.Alloc_dst = 0;
        bus.CDB_valid = 0; bus.CDB_tag = 0; bus.CDB_data = 0; bus.Uf_ready = 1;
    endtask

    task automatic alloc(input logic [15:0] vj, input logic [2:0] qj, input logic [2:0] dst);
        bus.Alloc_valid = 1; bus.Alloc_op = 0; bus.Alloc_Vj = vj; bus.Alloc_Vk = 0;
        bus.Alloc_Qj = qj; bus.Alloc_Qk = 0; bus.Alloc_use_A = 0; bus.Alloc_dst = dst;
    endtask

    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, bus.Uf_valid, 0);
        chk({name, "_op0"}, bus.Uf_op0, SEM);
        chk({name, "_op1"}, bus.Uf_op1, SEM);
        chk({name, "_op2"}, bus.Uf_op2, SEM);
        chk({name, "_busy"}, bus.Busy_mask, 0);
        chk({name, "_ardy"}, bus.Alloc_ready, 1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_busy[i] = 0;
        m_valid = 0; m_o0 = SEM; m_o1 = SEM; m_o2 = SEM; m_uop = 0; m_udst = 0; m_rr = 0;
    endtask

    // one clock edge of the specified behaviour, from the inputs currently driven
    task automatic model_step();
        int fi, j, c;
        if (bus.Flush) begin
            for (int i = 0; i < N; i++) m_busy[i] = 0;
            m_valid = 0; m_o0 = SEM; m_o1 = SEM; m_o2 = SEM; m_uop = 0; m_udst = 0;
            return;
        end
        fi = -1;
        for (int i = 0; i < N; i++) if (!m_busy[i] && fi < 0) fi = i;
        if (!m_valid || bus.Uf_ready) begin
            j = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (j < 0 && m_busy[c] && m_qj[c] == 0 && m_qk[c] == 0) j = c;
            end
            if (j >= 0) begin
                m_valid = 1; m_o0 = m_vk[j]; m_o1 = m_vj[j];
                m_o2 = m_ua[j] ? {9'd0, m_a[j]} : m_vk[j];
                m_uop = m_op[j]; m_udst = m_dst[j]; m_busy[j] = 0; m_rr = (j + 1) % N;
            end else begin
                m_valid = 0; m_o0 = SEM; m_o1 = SEM; m_o2 = SEM;
            end
        end
        if (bus.CDB_valid && bus.CDB_tag != 0)
            for (int i = 0; i < N; i++) if (m_busy[i]) begin
                if (m_qj[i] == bus.CDB_tag) begin m_vj[i] = bus.CDB_data; m_qj[i] = 0; end
                if (m_qk[i] == bus.CDB_tag) begin m_vk[i] = bus.CDB_data; m_qk[i] = 0; end
            end
        if (bus.Alloc_valid && fi >= 0) begin
            m_busy[fi] = 1; m_op[fi] = bus.Alloc_op; m_dst[fi] = bus.Alloc_dst;
            m_a[fi] = bus.Alloc_A; m_ua[fi] = bus.Alloc_use_A;
            m_vj[fi] = bus.Alloc_Vj; m_qj[fi] = bus.Alloc_Qj;
            m_vk[fi] = bus.Alloc_Vk; m_qk[fi] = bus.Alloc_Qk;
            if (bus.CDB_valid && bus.CDB_tag != 0 && bus.CDB_tag == m_qj[fi]) begin m_vj[fi] = bus.CDB_data; m_qj[fi] = 0; end
            if (bus.CDB_valid && bus.CDB_tag != 0 && bus.CDB_tag == m_qk[fi]) begin m_vk[fi] = bus.CDB_data; m_qk[fi] = 0; end
        end
    endtask

    task automatic model_cmp();
        logic [3:0] mb;
        for (int i = 0; i < N; i++) mb[i] = m_busy[i];
        chk("rnd_valid", bus.Uf_valid, m_valid);
        chk("rnd_op0", bus.Uf_op0, m_o0);
        chk("rnd_op1", bus.Uf_op1, m_o1);
        chk("rnd_op2", bus.Uf_op2, m_o2);
        chk("rnd_busy", bus.Busy_mask, mb);
        chk("rnd_ardy", bus.Alloc_ready, mb != 4'hF);
        if (m_valid) begin
            chk("rnd_uop", bus.Uf_op, m_uop);
            chk("rnd_dst", bus.Uf_dst, m_udst);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] seq_op1 [5];
        logic [2:0] seq_dst [5];
        logic stall;
        logic [15:0] held;
        //          av op vj        vk        qj qk a      ua dst cv ct cd        ur busy v  e0        e1        e2        dst
        tv[0]  = '{1, 5, 16'h0100, 16'h0077, 0, 0, 7'h05, 1, 1, 0, 0, 16'h0000, 1, 4'h1, 0, SEM, SEM, SEM, 0};
        tv[1]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 7'h00, 0, 0, 0, 0, 16'h0000, 1, 4'h0, 1, 16'h0077, 16'h0100, 16'h0005, 1};
        tv[2]  = '{1, 0, 16'hAAAA, 16'hBBBB, 3, 3, 7'h00, 0, 2, 0, 0, 16'h0000, 1, 4'h1, 0, SEM, SEM, SEM, 0};
        tv[3]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 7'h00, 0, 0, 1, 3, 16'h1234, 1, 4'h1, 0, SEM, SEM, SEM, 0};
        tv[4]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 7'h00, 0, 0, 0, 0, 16'h0000, 1, 4'h0, 1, 16'h1234, 16'h1234, 16'h1234, 2};
        tv[5]  = '{1, 6, 16'h0000, 16'h5555, 2, 0, 7'h7F, 1, 3, 1, 2, 16'hBEEF, 1, 4'h1, 0, SEM, SEM, SEM, 0};
        tv[6]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 7'h00, 0, 0, 0, 0, 16'h0000, 1, 4'h0, 1, 16'h5555, 16'hBEEF, 16'h007F, 3};
        tv[7]  = '{1, 0, 16'h1111, 16'h2222, 4, 0, 7'h00, 0, 4, 1, 0, 16'h9999, 1, 4'h1, 0, SEM, SEM, SEM, 0};
        tv[8]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 7'h00, 0, 0, 1, 5, 16'h8888, 1, 4'h1, 0, SEM, SEM, SEM, 0};
        tv[9]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 7'h00, 0, 0, 1, 4, 16'h4444, 1, 4'h1, 0, SEM, SEM, SEM, 0};
        tv[10] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 7'h00, 0, 0, 0, 0, 16'h0000, 0, 4'h0, 1, 16'h2222, 16'h4444, 16'h2222, 4};
        tv[11] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 7'h00, 0, 0, 0, 0, 16'h0000, 1, 4'h0, 0, SEM, SEM, SEM, 0};

        Reset = 1;
        idle_in();
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 0;
        chk_idle("reset");
        chk("reset_uop", bus.Uf_op, 0);
        chk("reset_dst", bus.Uf_dst, 0);

        for (int i = 0; i < 12; i++) begin
            bus.Alloc_valid = tv[i].av; bus.Alloc_op = tv[i].op; bus.Alloc_Vj = tv[i].vj;
            bus.Alloc_Vk = tv[i].vk; bus.Alloc_Qj = tv[i].qj; bus.Alloc_Qk = tv[i].qk;
            bus.Alloc_A = tv[i].a; bus.Alloc_use_A = tv[i].ua; bus.Alloc_dst = tv[i].dst;
            bus.CDB_valid = tv[i].cv; bus.CDB_tag = tv[i].ct; bus.CDB_data = tv[i].cd;
            bus.Uf_ready = tv[i].ur;
            cyc();
            chk($sformatf("tv%0d_valid", i), bus.Uf_valid, tv[i].e_valid);
            chk($sformatf("tv%0d_op0", i), bus.Uf_op0, tv[i].e0);
            chk($sformatf("tv%0d_op1", i), bus.Uf_op1, tv[i].e1);
            chk($sformatf("tv%0d_op2", i), bus.Uf_op2, tv[i].e2);
            chk($sformatf("tv%0d_busy", i), bus.Busy_mask, tv[i].e_busy);
            chk($sformatf("tv%0d_ardy", i), bus.Alloc_ready, tv[i].e_busy != 4'hF);
            if (tv[i].e_valid) chk($sformatf("tv%0d_dst", i), bus.Uf_dst, tv[i].e_dst);
        end

        // fill all entries under backpressure; the first op leaves at once (output was empty)
        Reset = 1;
        idle_in();
        @(negedge Clock);
        Reset = 0;
        bus.Uf_ready = 0;
        for (int k = 0; k < 5; k++) begin
            alloc(16'h0010 + 16'(k), 0, 3'(k));
            cyc();
        end
        for (int s = 0; s < 3; s++) begin
            alloc(16'h0099, 0, 7);
            chk("full_ardy", bus.Alloc_ready, 0);
            chk("full_busy", bus.Busy_mask, 4'hF);
            chk("full_valid", bus.Uf_valid, 1);
            chk("full_op1", bus.Uf_op1, 16'h0010);
            cyc();
        end
        // ops 1..4 sit in entries 1,0,2,3; rr_ptr=1 drains entries 1,2,3,0
        seq_op1 = '{16'h0011, 16'h0013, 16'h0014, 16'h0012, 16'h0000};
        seq_dst = '{3'd1, 3'd3, 3'd4, 3'd2, 3'd0};
        idle_in();
        for (int s = 0; s < 4; s++) begin
            cyc();
            chk($sformatf("drain%0d_valid", s), bus.Uf_valid, 1);
            chk($sformatf("drain%0d_op1", s), bus.Uf_op1, seq_op1[s]);
            chk($sformatf("drain%0d_dst", s), bus.Uf_dst, seq_dst[s]);
        end
        cyc();
        chk_idle("drained");

        // two ready ops with toggling ready: each accepted exactly once, held while stalled
        bus.Uf_ready = 0;
        alloc(16'h0021, 0, 5);
        cyc();
        alloc(16'h0022, 0, 6);
        cyc();
        idle_in();
        stall = 0;
        held = 0;
        for (int i = 0; i < 12; i++) begin
            if (stall) begin
                chk("stall_valid", bus.Uf_valid, 1);
                chk("stall_op1", bus.Uf_op1, held);
            end
            bus.Uf_ready = logic'(i % 2);
            if (bus.Uf_valid && bus.Uf_ready) acc.push_back(bus.Uf_op1);
            stall = bus.Uf_valid && !bus.Uf_ready;
            held = bus.Uf_op1;
            cyc();
        end
        chk("toggle_count", acc.size(), 2);
        if (acc.size() >= 2) begin
            chk("toggle_first", acc[0], 16'h0021);
            chk("toggle_second", acc[1], 16'h0022);
        end
        chk("toggle_busy", bus.Busy_mask, 0);

        // flush beats a concurrent alloc and broadcast
        bus.Uf_ready = 0;
        alloc(16'h0031, 0, 1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            alloc(16'h0032, 7, 2);
            cyc();
        end
        idle_in();
        bus.Uf_ready = 0;
        chk("preflush_busy", bus.Busy_mask, 4'h7);
        chk("preflush_valid", bus.Uf_valid, 1);
        chk("preflush_op1", bus.Uf_op1, 16'h0031);
        bus.Flush = 1;
        alloc(16'h0041, 0, 3);
        bus.CDB_valid = 1; bus.CDB_tag = 7; bus.CDB_data = 16'h7777;
        cyc();
        idle_in();
        chk_idle("flush");
        cyc();
        chk_idle("postflush");

        // asynchronous reset between clock edges
        bus.Uf_ready = 0;
        alloc(16'h0051, 0, 1);
        cyc();
        alloc(16'h0052, 7, 2);
        cyc();
        idle_in();
        bus.Uf_ready = 0;
        chk("prerst_valid", bus.Uf_valid, 1);
        chk("prerst_busy", bus.Busy_mask, 4'h2);
        #2;
        Reset = 1;
        #1;
        chk_idle("async_rst");
        chk("async_rst_uop", bus.Uf_op, 0);
        chk("async_rst_dst", bus.Uf_dst, 0);
        @(negedge Clock);
        Reset = 0;
        idle_in();

        // random traffic against the reference model
        model_reset();
        for (int n = 0; n < 800; n++) begin
            model_cmp();
            bus.Flush = ($urandom_range(0, 49) == 0);
            bus.Alloc_valid = ($urandom_range(0, 9) < 6);
            bus.Alloc_op = 3'($urandom);
            bus.Alloc_Vj = 16'($urandom);
            bus.Alloc_Vk = 16'($urandom);
            bus.Alloc_Qj = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            bus.Alloc_Qk = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            bus.Alloc_A = 7'($urandom);
            bus.Alloc_use_A = 1'($urandom);
            bus.Alloc_dst = 3'($urandom);
            bus.CDB_valid = 1'($urandom);
            bus.CDB_tag = 3'($urandom);
            bus.CDB_data = 16'($urandom);
            bus.Uf_ready = ($urandom_range(0, 9) < 7);
            @(posedge Clock);
            model_step();
            @(negedge Clock);
        end
        model_cmp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
